r4u4_twid_ctrl: RTL
===================

R4U4_TWID_CTRL -- requirements
Module: r4u4_twid_ctrl

Interface
REQ-001 SHALL have parameter MAN_W, default `MAN_WIDTH, meaning mantissa width of the sample path.
REQ-002 SHALL have parameter EXP_W, default `EXP_WIDTH, meaning block-exponent width.
REQ-003 SHALL have port clk_sys, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_sys_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_ldn_i, input, 4, log2 FFT size: 10 means 1024 points, 11 means 2048 points.
REQ-006 SHALL have port frm_start_i, input, 1, first-sample marker; valid only together with in_val_i.
REQ-007 SHALL have port in_val_i, input, 1, input sample valid.
REQ-008 SHALL have ports in_real_i and in_imag_i, input, signed MAN_W each, sample mantissas.
REQ-009 SHALL have port in_exp_i, input, signed EXP_W, sample exponent.
REQ-010 SHALL have ports block_sync_o, stage_sync_o and data_val_o, output, 1 each, control to the twiddle multiplier.
REQ-011 SHALL have ports data_real_o and data_imag_o (signed MAN_W each) and data_exp_o (signed EXP_W), output, registered sample copy.
REQ-012 SHALL have port ldn_rg_o, output, 4, latched frame size.
REQ-013 SHALL have ports k1_o and k2_o, output, 1 each, twiddle segment select.
REQ-014 SHALL have ports busy_o, frm_done_o and err_o, output, 1 each: frame in progress, last-sample pulse, protocol-error pulse.

Function
REQ-015 SHALL define N = 2^ldn, where ldn is the value latched at frame start; any cfg_ldn_i value other than 10 or 11 SHALL be latched as 11 and SHALL pulse err_o.
REQ-016 SHALL implement states IDLE and RUN, an 11-bit valid-sample counter idx, and hold the latched ldn for the whole frame.
REQ-017 SHALL, in IDLE with in_val_i=1 and frm_start_i=1: latch cfg_ldn_i, emit the sample as idx=0, set idx to 1, and go to RUN.
REQ-018 SHALL, in IDLE with in_val_i=1 and frm_start_i=0: drop the sample (data_val_o stays 0) and pulse err_o.
REQ-019 SHALL, in RUN, advance idx only on in_val_i=1; gaps SHALL hold idx and all outputs SHALL be 0 during a gap.
REQ-020 SHALL, in RUN at the sample with idx=N-1: pulse frm_done_o with that sample and return to IDLE.
REQ-021 SHALL, in RUN with frm_start_i=1 and in_val_i=1: abort the current frame, pulse err_o, and treat the sample as idx=0 of a new frame (relatch ldn, block_sync_o=1, remain in RUN).
REQ-022 SHALL compute segment s = idx / (N/4) in the range 0..3, with k1 = s[1] and k2 = s[0] (segment order W-exponent multipliers 0, 2, 1, 3).
REQ-023 SHALL drive all outputs registered, with latency 1 cycle from in_val_i to data_val_o.
REQ-024 SHALL assert block_sync_o with the output sample idx=0.
REQ-025 SHALL assert stage_sync_o with the output samples idx=0, N/4, N/2 and 3N/4.
REQ-026 SHALL hold k1_o and k2_o at the values for the current output sample; they SHALL be 0 when data_val_o=0.
REQ-027 SHALL set data_real_o, data_imag_o and data_exp_o to the sample delayed one cycle when it is emitted, and to 0 otherwise.
REQ-028 SHALL assert busy_o while the state is RUN (registered view); ldn_rg_o SHALL show the latched ldn.
REQ-029 SHALL ignore cfg_ldn_i changes during RUN.

Reset
REQ-030 SHALL, on rst_sys_n=0, asynchronously force: state to IDLE, idx to 0, ldn latch to 11, and all outputs to 0 except ldn_rg_o, which SHALL be 11.
REQ-031 SHALL discard a partial frame on reset mid-operation, with no frm_done_o or err_o, and accept a new frame on the first frm_start_i after release.

Verification
REQ-032 SHALL be verified with this scenario: ldn=10, 1024 contiguous valid samples with start on the first -> block_sync at out 0; stage_sync at outs 0, 256, 512 and 768; (k1,k2) = 00, 01, 10, 11 per quarter; frm_done at out 1023; busy low afterwards.
REQ-033 SHALL be verified with this scenario: ldn=11 with random in_val gaps -> stage_sync at valid-sample counts 0, 512, 1024 and 1536; no outputs during gaps; frm_done on the 2048th valid sample.
REQ-034 SHALL be verified with this scenario: frm_start at sample 300 of a 1024-point frame -> err pulse, block_sync at that sample, and a new frame completing 1023 samples later.
REQ-035 SHALL be verified with this scenario: in_val without frm_start in IDLE, and cfg_ldn_i=9 at start -> sample dropped with err pulse; ldn_rg_o=11 with an err pulse.
REQ-036 SHALL be verified with this scenario: reset asserted at sample 700 -> all outputs 0 immediately and ldn_rg_o=11; the next frame after release behaves as in REQ-032.

Source files
------------

// File: rtl/r4u4_twid_ctrl_if.sv
// Sample-path interface of the radix-4 twiddle controller: upstream samples in,
// registered samples plus twiddle control out to the multiplier.
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif

interface r4u4_twid_ctrl_if #(
    parameter int MAN_W = `MAN_WIDTH,
    parameter int EXP_W = `EXP_WIDTH
) ();
    logic                    frm_start_i;
    logic                    in_val_i;
    logic signed [MAN_W-1:0] in_real_i;
    logic signed [MAN_W-1:0] in_imag_i;
    logic signed [EXP_W-1:0] in_exp_i;

    logic                    block_sync_o;
    logic                    stage_sync_o;
    logic                    data_val_o;
    logic signed [MAN_W-1:0] data_real_o;
    logic signed [MAN_W-1:0] data_imag_o;
    logic signed [EXP_W-1:0] data_exp_o;
    logic                    k1_o;
    logic                    k2_o;

    modport master (
        output frm_start_i, in_val_i, in_real_i, in_imag_i, in_exp_i,
        input  block_sync_o, stage_sync_o, data_val_o,
        input  data_real_o, data_imag_o, data_exp_o, k1_o, k2_o
    );

    modport slave (
        input  frm_start_i, in_val_i, in_real_i, in_imag_i, in_exp_i,
        output block_sync_o, stage_sync_o, data_val_o,
        output data_real_o, data_imag_o, data_exp_o, k1_o, k2_o
    );
endinterface

// File: rtl/r4u4_twid_ctrl.sv
// Frame sequencer for a 1024/2048-point radix-4 stage: counts valid samples,
// emits block/stage syncs and the twiddle segment select one cycle after input.
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif

module r4u4_twid_ctrl #(
    parameter int MAN_W = `MAN_WIDTH,
    parameter int EXP_W = `EXP_WIDTH
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    input  logic [3:0]            cfg_ldn_i,
    r4u4_twid_ctrl_if.slave       sif,
    output logic [3:0]            ldn_rg_o,
    output logic                  busy_o,
    output logic                  frm_done_o,
    output logic                  err_o
);
    localparam int unsigned IDX_W = 11;
    localparam int unsigned LDN_W = 4;
    localparam logic [LDN_W-1:0] LDN_1K = LDN_W'(10);
    localparam logic [LDN_W-1:0] LDN_2K = LDN_W'(11);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LDN_W-1:0]      ldn_q, ldn_d;

    logic                  blk_q, blk_d, stg_q, stg_d, val_q, val_d;
    logic                  k1_q, k1_d, k2_q, k2_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic signed [MAN_W-1:0] re_q, re_d, im_q, im_d;
    logic signed [EXP_W-1:0] ex_q, ex_d;

    logic                  start_c, cfg_ok_c, emit_c, last_c, qzero_c, err_c;
    logic [IDX_W-1:0]      cur_idx_c;
    logic [LDN_W-1:0]      cur_ldn_c;
    logic [1:0]            seg_c;

    // Decode of the incoming sample: which frame index it takes and under which size.
    always_comb begin
        start_c   = sif.in_val_i & sif.frm_start_i;
        cfg_ok_c  = (cfg_ldn_i == LDN_1K) || (cfg_ldn_i == LDN_2K);
        cur_ldn_c = start_c ? (cfg_ok_c ? cfg_ldn_i : LDN_2K) : ldn_q;
        cur_idx_c = start_c ? '0 : idx_q;
        emit_c    = sif.in_val_i & (start_c | (state_q == ST_RUN));
        if (cur_ldn_c == LDN_1K) begin
            last_c  = emit_c & (cur_idx_c == IDX_W'(1023));
            seg_c   = cur_idx_c[9:8];
            qzero_c = (cur_idx_c[7:0] == 8'd0);
        end else begin
            last_c  = emit_c & (cur_idx_c == IDX_W'(2047));
            seg_c   = cur_idx_c[10:9];
            qzero_c = (cur_idx_c[8:0] == 9'd0);
        end
        err_c = (start_c & (~cfg_ok_c | (state_q == ST_RUN)))
              | (sif.in_val_i & ~sif.frm_start_i & (state_q == ST_IDLE));
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ldn_q   <= LDN_2K;
            blk_q   <= 1'b0;
            stg_q   <= 1'b0;
            val_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            ex_q    <= '0;
            k1_q    <= 1'b0;
            k2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ldn_q   <= ldn_d;
            blk_q   <= blk_d;
            stg_q   <= stg_d;
            val_q   <= val_d;
            re_q    <= re_d;
            im_q    <= im_d;
            ex_q    <= ex_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state: an accepted sample advances idx, the last one closes the frame.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ldn_d   = ldn_q;
        if (emit_c) begin
            ldn_d   = cur_ldn_c;
            idx_d   = last_c ? '0 : cur_idx_c + IDX_W'(1);
            state_d = last_c ? ST_IDLE : ST_RUN;
        end
    end

    // Outputs: everything except busy/err is zero unless a sample is emitted.
    always_comb begin
        blk_d  = 1'b0;
        stg_d  = 1'b0;
        val_d  = emit_c;
        re_d   = '0;
        im_d   = '0;
        ex_d   = '0;
        k1_d   = 1'b0;
        k2_d   = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d == ST_RUN);
        err_d  = err_c;
        if (emit_c) begin
            blk_d  = (cur_idx_c == '0);
            stg_d  = qzero_c;
            re_d   = sif.in_real_i;
            im_d   = sif.in_imag_i;
            ex_d   = sif.in_exp_i;
            k1_d   = seg_c[1];
            k2_d   = seg_c[0];
            done_d = last_c;
        end
    end

    assign sif.block_sync_o = blk_q;
    assign sif.stage_sync_o = stg_q;
    assign sif.data_val_o   = val_q;
    assign sif.data_real_o  = re_q;
    assign sif.data_imag_o  = im_q;
    assign sif.data_exp_o   = ex_q;
    assign sif.k1_o         = k1_q;
    assign sif.k2_o         = k2_q;
    assign ldn_rg_o         = ldn_q;
    assign busy_o           = busy_q;
    assign frm_done_o       = done_q;
    assign err_o            = err_q;
endmodule
